// File: rtl/lane_sequencer.sv
// lane_sequencer
// Four-way round-robin lane sequencer placed in front of a shared
// green/orange phase timer. It synchronises the raw presence sensors and
// picks the next occupied lane after the current one. Between lanes it
// holds an all-red clearance. It drives the timer's Traffic input and its
// reset, and fans the timer lamp state out to registered per-lane lamps.
//
// Ports:
//   Clk         in   system clock, rising edge
//   Rst         in   asynchronous active-low reset
//   Sense[3:0]  in   raw vehicle presence per lane (asynchronous)
//   Tmr_Next    in   timer end-of-phase
//   Tmr_Green   in   timer green
//   Tmr_Orange  in   timer orange
//   Tmr_Traffic out  demand toward the timer for the active lane
//   Tmr_Rst     out  holds the timer at its start state (active-high)
//   Lane[1:0]   out  currently selected lane
//   Green[3:0]  out  per-lane green lamp (registered)
//   Orange[3:0] out  per-lane orange lamp (registered)
//   Red[3:0]    out  per-lane red lamp (registered)
//
// Timer interface: the timer has no handshake. Tmr_Next is sampled only in
// RUN, as a single-cycle end-of-phase strobe. In every other state it is
// ignored.
module lane_sequencer #(
   parameter int ALLRED_CYC = 2,
   parameter int MAX_RUN    = 64
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [3:0] Sense,
   input  logic       Tmr_Next,
   input  logic       Tmr_Green,
   input  logic       Tmr_Orange,
   output logic       Tmr_Traffic,
   output logic       Tmr_Rst,
   output logic [1:0] Lane,
   output logic [3:0] Green,
   output logic [3:0] Orange,
   output logic [3:0] Red
);

   localparam int CW = (ALLRED_CYC > 1) ? $clog2(ALLRED_CYC) : 1;
   localparam int RW = $clog2(MAX_RUN + 1);
   localparam logic [CW-1:0] CLR_LOAD = CW'(ALLRED_CYC - 1);
   localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_RUN);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_PICK  = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [3:0]      sns_meta_q, sns_q;
   logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
   logic [RW-1:0]   run_cnt_q, run_cnt_d;
   logic [1:0]      lane_q, lane_d;
   logic [3:0]      grn_q, grn_d;
   logic [3:0]      org_q, org_d;
   logic [3:0]      red_q, red_d;
   logic            wd_expired;
   logic            found;
   logic [1:0]      pick_lane;
   logic [1:0]      cand;

   // Two-flop synchroniser per sensor bit.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         sns_meta_q <= '0;
         sns_q      <= '0;
      end else begin
         sns_meta_q <= Sense;
         sns_q      <= sns_meta_q;
      end
   end

   assign wd_expired = (run_cnt_q == RUN_MAX);

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      run_cnt_d = run_cnt_q;
      lane_d    = lane_q;
      grn_d     = '0;
      org_d     = '0;
      found     = 1'b0;
      pick_lane = lane_q;
      cand      = lane_q;

      // Scan from Lane+4 (the current lane) down to Lane+1, so that the
      // last hit is the one nearest after the current lane.
      for (int k = 4; k >= 1; k--) begin
         cand = lane_q + 2'(k);
         if (sns_q[cand]) begin
            found     = 1'b1;
            pick_lane = cand;
         end
      end

      case (state_q)
         ST_CLEAR: begin
            if (clr_cnt_q == '0) state_d = ST_PICK;
            else                 clr_cnt_d = clr_cnt_q - CW'(1);
         end
         ST_PICK: begin
            if (found) begin
               lane_d    = pick_lane;
               run_cnt_d = '0;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (Tmr_Next) begin
               // Exit wins over everything else, including the lamp
               // values the timer shows in this cycle.
               state_d   = ST_CLEAR;
               clr_cnt_d = CLR_LOAD;
            end else begin
               if (!wd_expired) run_cnt_d = run_cnt_q + RW'(1);
               grn_d[lane_q] = Tmr_Green & ~Tmr_Orange;
               org_d[lane_q] = Tmr_Orange;
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = CLR_LOAD;
         end
      endcase

      red_d = ~(grn_d | org_d);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= CLR_LOAD;
         run_cnt_q <= '0;
         lane_q    <= 2'd3;
         grn_q     <= '0;
         org_q     <= '0;
         red_q     <= 4'b1111;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         run_cnt_q <= run_cnt_d;
         lane_q    <= lane_d;
         grn_q     <= grn_d;
         org_q     <= org_d;
         red_q     <= red_d;
      end
   end

   assign Tmr_Rst     = (state_q != ST_RUN);
   assign Tmr_Traffic = (state_q == ST_RUN) & sns_q[lane_q] & ~wd_expired;
   assign Lane        = lane_q;
   assign Green       = grn_q;
   assign Orange      = org_q;
   assign Red         = red_q;

endmodule
